// File: rtl/lp_laser_packer.sv
// Packs pairs of low-pass samples into double-width words, queues them in a show-ahead FIFO,
// and closes each acquisition window with an optional padded word and a sample-count trailer.
module lp_laser_packer #(
  parameter real TCQ        = 0.1,
  parameter int  DATA_WIDTH = 16,
  parameter int  FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          laser_start_i,
  input  logic                          lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0]         lp_laser_data_i,
  output logic                          pack_vld_o,
  output logic [2*DATA_WIDTH-1:0]       pack_data_o,
  output logic                          pack_last_o,
  input  logic                          pack_rdy_i,
  output logic                          overflow_o,
  output logic [15:0]                   drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = 2 * DATA_WIDTH;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lp_laser_packer: FIFO_DEPTH must be a power of two and at least 4");
  end
  if (TCQ < 0.0) begin : g_bad_tcq
    $error("lp_laser_packer: TCQ must not be negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAD, S_TRAIL} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] half_q;
  logic                  half_vld_q;
  logic [WW-1:0]         cnt_q;
  logic                  overflow_q;
  logic [15:0]           drop_q;
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [WW:0]           mem [FIFO_DEPTH];

  logic [AW:0] level;
  logic        empty, full, pop, can_write, accept, pair;
  logic        push, drop, start_frame;
  logic [WW:0] push_word, head;

  // Extra pointer bit distinguishes full from empty; the difference is the occupancy.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign empty     = (level == '0);
  assign full      = (level == (AW+1)'(FIFO_DEPTH));
  assign pop       = !empty && pack_rdy_i;
  assign can_write = !full || pop;
  assign accept    = (state_q == S_RUN) && laser_start_i && lp_laser_vld_i;
  assign pair      = accept && half_vld_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    push        = 1'b0;
    drop        = 1'b0;
    start_frame = 1'b0;
    push_word   = {1'b0, lp_laser_data_i, half_q};
    case (state_q)
      S_IDLE: begin
        if (laser_start_i) begin
          state_d     = S_RUN;
          start_frame = 1'b1;
        end
      end
      S_RUN: begin
        if (!laser_start_i) begin
          state_d = half_vld_q ? S_PAD : S_TRAIL;
        end else if (pair) begin
          push = can_write;
          drop = !can_write;
        end
      end
      S_PAD: begin
        push_word = {1'b0, {DATA_WIDTH{1'b0}}, half_q};
        if (can_write) begin
          push    = 1'b1;
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        push_word = {1'b1, cnt_q};
        if (can_write) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      half_q     <= '0;
      half_vld_q <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      // A dropped pair still releases the half register so pairing stays aligned.
      if (start_frame) begin
        half_vld_q <= 1'b0;
      end else if (accept) begin
        if (half_vld_q) begin
          half_vld_q <= 1'b0;
        end else begin
          half_q     <= lp_laser_data_i;
          half_vld_q <= 1'b1;
        end
      end else if (state_q == S_PAD && push) begin
        half_vld_q <= 1'b0;
      end

      if (start_frame)                 cnt_q <= '0;
      else if (accept && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;

      if (start_frame) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from the pointers, and the head is gated.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_word;
  end

  assign head         = mem[rd_ptr_q[AW-1:0]];
  assign pack_vld_o   = !empty;
  assign pack_data_o  = empty ? '0 : head[WW-1:0];
  assign pack_last_o  = !empty && head[WW];
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_q;
  assign fifo_level_o = level;

endmodule
